// File: rtl/vga_timing_rx.sv
// vga_timing_rx: recovers pixel coordinates and data-enable from a parallel
// VGA stream and checks line/frame timing against the nominal geometry.
// Optional build macro VGA_RX_CHECKSUM_EN adds a per-frame RGB checksum
// (frame_sum / sum_valid).
//
// state   | meaning
// SEARCH  | waiting for a vs fall to start measuring
// MEASURE | counting one full frame, any violation restarts the search
// LOCKED  | timing verified, de and frame_start are driven
module vga_timing_rx #(
  parameter int LinePeriod  = 800,
  parameter int H_SyncPulse = 96,
  parameter int H_BackPorch = 48,
  parameter int H_ActivePix = 640,
  parameter int FramePeriod = 525,
  parameter int V_SyncPulse = 2,
  parameter int V_BackPorch = 33,
  parameter int V_ActivePix = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vga_hs,
  input  logic        vga_vs,
  input  logic [7:0]  vga_r,
  input  logic [7:0]  vga_g,
  input  logic [7:0]  vga_b,
  output logic        de,
  output logic [9:0]  px_x,
  output logic [9:0]  px_y,
  output logic [7:0]  px_r,
  output logic [7:0]  px_g,
  output logic [7:0]  px_b,
  output logic        frame_start,
  output logic        locked,
  output logic        err,
  output logic [7:0]  err_cnt,
  output logic [10:0] meas_line_len,
  output logic [9:0]  meas_frame_lines
`ifdef VGA_RX_CHECKSUM_EN
  ,
  output logic [15:0] frame_sum,
  output logic        sum_valid
`endif
);

  localparam int HStart = H_SyncPulse + H_BackPorch;
  localparam int HEnd   = HStart + H_ActivePix;
  localparam int VStart = V_SyncPulse + V_BackPorch;
  localparam int VEnd   = VStart + V_ActivePix;

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  state_t      state_q, state_nx;
  logic        hs_q, vs_q;
  logic        line_seen, frame_seen;
  logic [10:0] h_pos, h_inc, h_now;
  logic [9:0]  v_pos, v_inc, v_now;
  logic [11:0] h_len;
  logic [10:0] v_len;
  logic        hs_fall, hs_rise, vs_fall, vs_rise;
  logic        chk_a, chk_b, chk_c, chk_d, viol;
  logic        active, de_nx, fs_nx;

  // Edge detection, position tracking and timing checks. h_pos/v_pos hold
  // the position of the previous sample, so h_pos + 1 is the length of the
  // line that ends at an hs fall (the pre-reload value).
  always_comb begin
    hs_fall = hs_q & ~vga_hs;
    hs_rise = ~hs_q & vga_hs;
    vs_fall = hs_fall & vs_q & ~vga_vs;
    vs_rise = hs_fall & ~vs_q & vga_vs;
    h_inc   = (h_pos == 11'h7FF) ? h_pos : h_pos + 11'd1;
    h_now   = hs_fall ? 11'd0 : h_inc;
    v_inc   = (v_pos == 10'h3FF) ? v_pos : v_pos + 10'd1;
    v_now   = hs_fall ? (vs_fall ? 10'd0 : v_inc) : v_pos;
    h_len   = {1'b0, h_pos} + 12'd1;
    v_len   = {1'b0, v_pos} + 11'd1;
    chk_a   = hs_fall & (h_len != 12'(LinePeriod));
    chk_b   = hs_rise & (h_len != 12'(H_SyncPulse));
    chk_c   = vs_fall & (v_len != 11'(FramePeriod));
    chk_d   = hs_fall & ~vs_fall & (vs_rise != (v_len == 11'(V_SyncPulse)));
    viol    = (state_q != SEARCH) & (chk_a | chk_b | chk_c | chk_d);
    active  = (h_now >= 11'(HStart)) && (h_now < 11'(HEnd)) &&
              (v_now >= 10'(VStart)) && (v_now < 10'(VEnd));
  end

  // Next-state logic; de is gated with the next state so a violation blanks
  // it on the same clock that locked drops.
  always_comb begin
    state_nx = state_q;
    case (state_q)
      SEARCH:  if (vs_fall) state_nx = MEASURE;
      MEASURE: if (viol) state_nx = SEARCH;
               else if (vs_fall) state_nx = LOCKED;
      LOCKED:  if (viol) state_nx = SEARCH;
      default: state_nx = SEARCH;
    endcase
    de_nx = active & (state_nx == LOCKED);
    fs_nx = de_nx && (h_now == 11'(HStart)) && (v_now == 10'(VStart));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= SEARCH;
    else     state_q <= state_nx;
  end

  assign locked = (state_q == LOCKED);

  // Sync history, position counters and first-edge flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_q       <= 1'b1;
      vs_q       <= 1'b1;
      h_pos      <= '0;
      v_pos      <= '0;
      line_seen  <= 1'b0;
      frame_seen <= 1'b0;
    end else begin
      hs_q  <= vga_hs;
      h_pos <= h_now;
      v_pos <= v_now;
      if (hs_fall) vs_q <= vga_vs;
      if (viol) begin
        line_seen  <= 1'b0;
        frame_seen <= 1'b0;
      end else begin
        if (hs_fall) line_seen <= 1'b1;
        if (vs_fall) frame_seen <= 1'b1;
      end
    end
  end

  // Measured geometry and error reporting.
  always_ff @(posedge clk) begin
    if (rst) begin
      meas_line_len    <= '0;
      meas_frame_lines <= '0;
      err              <= 1'b0;
      err_cnt          <= '0;
    end else begin
      if (hs_fall && line_seen) meas_line_len <= h_inc;
      if (vs_fall && frame_seen) meas_frame_lines <= v_inc;
      err <= viol;
      if (viol && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
    end
  end

  // Registered pixel outputs; coordinates and colour are zero outside de.
  always_ff @(posedge clk) begin
    if (rst) begin
      de          <= 1'b0;
      frame_start <= 1'b0;
      px_x        <= '0;
      px_y        <= '0;
      px_r        <= '0;
      px_g        <= '0;
      px_b        <= '0;
    end else begin
      de          <= de_nx;
      frame_start <= fs_nx;
      if (de_nx) begin
        px_x <= 10'(h_now - 11'(HStart));
        px_y <= v_now - 10'(VStart);
        px_r <= vga_r;
        px_g <= vga_g;
        px_b <= vga_b;
      end else begin
        px_x <= '0;
        px_y <= '0;
        px_r <= '0;
        px_g <= '0;
        px_b <= '0;
      end
    end
  end

`ifdef VGA_RX_CHECKSUM_EN
  logic [15:0] sum_acc;
  logic [15:0] pix_sum;

  assign pix_sum = {8'd0, px_r} + {8'd0, px_g} + {8'd0, px_b};

  // Per-frame checksum: restart at frame_start, publish at the next vs fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_acc   <= '0;
      frame_sum <= '0;
      sum_valid <= 1'b0;
    end else begin
      if (frame_start)  sum_acc <= pix_sum;
      else if (de)      sum_acc <= sum_acc + pix_sum;
      sum_valid <= vs_fall && (state_q == LOCKED);
      if (vs_fall && (state_q == LOCKED)) frame_sum <= sum_acc;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_rx.sv
// tb_vga_timing_rx: directed bench for vga_timing_rx on a reduced geometry
// (40 clocks x 20 lines, 24x12 active, active origin at h 10 / v 5).
module tb_vga_timing_rx;

  localparam int LP  = 40;
  localparam int HSW = 4;
  localparam int HBP = 6;
  localparam int HAP = 24;
  localparam int FP  = 20;
  localparam int VSW = 2;
  localparam int VBP = 3;
  localparam int VAP = 12;
  localparam int HST = HSW + HBP;
  localparam int VST = VSW + VBP;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vga_hs = 1'b1;
  logic        vga_vs = 1'b1;
  logic [7:0]  vga_r = '0, vga_g = '0, vga_b = '0;
  logic        de, frame_start, locked, err;
  logic [9:0]  px_x, px_y, meas_frame_lines;
  logic [7:0]  px_r, px_g, px_b, err_cnt;
  logic [10:0] meas_line_len;
`ifdef VGA_RX_CHECKSUM_EN
  logic [15:0] frame_sum;
  logic        sum_valid;
`endif

  vga_timing_rx #(
    .LinePeriod(LP), .H_SyncPulse(HSW), .H_BackPorch(HBP), .H_ActivePix(HAP),
    .FramePeriod(FP), .V_SyncPulse(VSW), .V_BackPorch(VBP), .V_ActivePix(VAP)
  ) dut (
    .clk(clk), .rst(rst), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .de(de), .px_x(px_x), .px_y(px_y), .px_r(px_r), .px_g(px_g), .px_b(px_b),
    .frame_start(frame_start), .locked(locked), .err(err), .err_cnt(err_cnt),
    .meas_line_len(meas_line_len), .meas_frame_lines(meas_frame_lines)
`ifdef VGA_RX_CHECKSUM_EN
    , .frame_sum(frame_sum), .sum_valid(sum_valid)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int g_hs_w = HSW;
  int g_short = -1;

  // observation counters, sampled on the falling edge
  int de_cnt = 0, fs_cnt = 0, fs_bad = 0, zero_bad = 0, red_cnt = 0, red_bad = 0;
  int err_pulses = 0, lock_rises = 0, hs_neg_cyc = 0, err_gap = -1, de_gap = -1;
  int err_cyc = -1, unlock_cyc = -2;
  logic [23:0] cap_a = '0, cap_b = '0, cap_c = '0;
  logic hs_p = 1'b1, de_p = 1'b0, err_p = 1'b0, lock_p = 1'b0;

  always @(negedge clk) begin
    if (hs_p && !vga_hs) hs_neg_cyc = cyc;
    if (de) de_cnt++;
    if (de && !de_p) de_gap = cyc - hs_neg_cyc;
    if (err) err_pulses++;
    if (err && !err_p) begin err_cyc = cyc; err_gap = cyc - hs_neg_cyc; end
    if (locked && !lock_p) lock_rises++;
    if (!locked && lock_p) unlock_cyc = cyc;
    if (frame_start) fs_cnt++;
    if (frame_start && !(de && px_x == 10'd0 && px_y == 10'd0)) fs_bad++;
    if (de && px_x == 10'd0 && px_y == 10'd0 && !frame_start) fs_bad++;
    if (!de && ({px_x, px_y} != 20'd0 || {px_r, px_g, px_b} != 24'd0)) zero_bad++;
    if (de && px_x < 10'd3) begin
      red_cnt++;
      if ({px_r, px_g} != 16'hff00) red_bad++;
    end
    if (de && px_x == 10'd1  && px_y == 10'd5) cap_a = {px_r, px_g, px_b};
    if (de && px_x == 10'd12 && px_y == 10'd6) cap_b = {px_r, px_g, px_b};
    if (de && px_x == 10'd22 && px_y == 10'd4) cap_c = {px_r, px_g, px_b};
    hs_p = vga_hs; de_p = de; err_p = err; lock_p = locked;
  end

  task automatic drive_raw(input logic hs, input logic vs, input logic [23:0] rgb);
    @(posedge clk);
    #1;
    vga_hs = hs;
    vga_vs = vs;
    {vga_r, vga_g, vga_b} = rgb;
  endtask

  // pattern: 3-column / 2-row red border around a white field
  task automatic drive_px(input int l, input int c);
    int x, y;
    logic [23:0] rgb;
    x = c - HST;
    y = l - VST;
    rgb = 24'h0;
    if (x >= 0 && x < HAP && y >= 0 && y < VAP)
      rgb = (x < 3 || x >= HAP - 3 || y < 2 || y >= VAP - 2) ? 24'hff0000 : 24'hffffff;
    drive_raw((c < g_hs_w) ? 1'b0 : 1'b1, (l < VSW) ? 1'b0 : 1'b1, rgb);
  endtask

  task automatic send_frame();
    int len;
    for (int l = 0; l < FP; l++) begin
      len = (l == g_short) ? LP - 1 : LP;
      for (int c = 0; c < len; c++) drive_px(l, c);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (de !== 1'b0) begin n_bad++; $display("FAIL reset_de: got %0d want 0", de); end
    n_cmp++; if (px_x !== 10'd0) begin n_bad++; $display("FAIL reset_px_x: got %0d want 0", px_x); end
    n_cmp++; if (px_y !== 10'd0) begin n_bad++; $display("FAIL reset_px_y: got %0d want 0", px_y); end
    n_cmp++; if ({px_r, px_g, px_b} !== 24'd0) begin n_bad++; $display("FAIL reset_rgb: got %h want 0", {px_r, px_g, px_b}); end
    n_cmp++; if (frame_start !== 1'b0) begin n_bad++; $display("FAIL reset_fs: got %0d want 0", frame_start); end
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL reset_locked: got %0d want 0", locked); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %0d want 0", err); end
    n_cmp++; if (err_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
    n_cmp++; if (meas_line_len !== 11'd0) begin n_bad++; $display("FAIL reset_line_len: got %0d want 0", meas_line_len); end
    n_cmp++; if (meas_frame_lines !== 10'd0) begin n_bad++; $display("FAIL reset_frame_lines: got %0d want 0", meas_frame_lines); end
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) drive_raw(1'b1, 1'b1, 24'h0);
  endtask

  task automatic test_loopback();
    int d0, f0, e0, l0;
    d0 = de_cnt; f0 = fs_cnt; e0 = err_pulses; l0 = lock_rises;
    send_frame();
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL loop_locked_f1: got %0d want 0", locked); end
    n_cmp++; if (de_cnt - d0 !== 0) begin n_bad++; $display("FAIL loop_de_f1: got %0d want 0", de_cnt - d0); end
    send_frame();
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL loop_locked_f2: got %0d want 1", locked); end
    send_frame();
    n_cmp++; if (de_cnt - d0 !== 2 * HAP * VAP) begin n_bad++; $display("FAIL loop_de_cnt: got %0d want %0d", de_cnt - d0, 2 * HAP * VAP); end
    n_cmp++; if (fs_cnt - f0 !== 2) begin n_bad++; $display("FAIL loop_fs_cnt: got %0d want 2", fs_cnt - f0); end
    n_cmp++; if (err_pulses - e0 !== 0) begin n_bad++; $display("FAIL loop_err: got %0d want 0", err_pulses - e0); end
    n_cmp++; if (err_cnt !== 8'd0) begin n_bad++; $display("FAIL loop_err_cnt: got %0d want 0", err_cnt); end
    n_cmp++; if (meas_line_len !== 11'(LP)) begin n_bad++; $display("FAIL loop_line_len: got %0d want %0d", meas_line_len, LP); end
    n_cmp++; if (meas_frame_lines !== 10'(FP)) begin n_bad++; $display("FAIL loop_frame_lines: got %0d want %0d", meas_frame_lines, FP); end
    n_cmp++; if (lock_rises - l0 !== 1) begin n_bad++; $display("FAIL loop_lock_rises: got %0d want 1", lock_rises - l0); end
  endtask

  task automatic test_pattern();
    int d0, f0, r0;
    d0 = de_cnt; f0 = fs_cnt; r0 = red_cnt;
    send_frame();
    n_cmp++; if (de_cnt - d0 !== HAP * VAP) begin n_bad++; $display("FAIL pat_de_cnt: got %0d want %0d", de_cnt - d0, HAP * VAP); end
    n_cmp++; if (fs_cnt - f0 !== 1) begin n_bad++; $display("FAIL pat_fs_cnt: got %0d want 1", fs_cnt - f0); end
    n_cmp++; if (fs_bad !== 0) begin n_bad++; $display("FAIL pat_fs_align: got %0d bad want 0", fs_bad); end
    n_cmp++; if (zero_bad !== 0) begin n_bad++; $display("FAIL pat_idle_zero: got %0d bad want 0", zero_bad); end
    n_cmp++; if (red_cnt - r0 !== 3 * VAP) begin n_bad++; $display("FAIL pat_red_cnt: got %0d want %0d", red_cnt - r0, 3 * VAP); end
    n_cmp++; if (red_bad !== 0) begin n_bad++; $display("FAIL pat_red_border: got %0d bad want 0", red_bad); end
    n_cmp++; if (cap_a !== 24'hff0000) begin n_bad++; $display("FAIL pat_px_1_5: got %h want ff0000", cap_a); end
    n_cmp++; if (cap_b !== 24'hffffff) begin n_bad++; $display("FAIL pat_px_12_6: got %h want ffffff", cap_b); end
    n_cmp++; if (cap_c !== 24'hff0000) begin n_bad++; $display("FAIL pat_px_22_4: got %h want ff0000", cap_c); end
    n_cmp++; if (de_gap !== HST + 1) begin n_bad++; $display("FAIL pat_de_latency: got %0d want %0d", de_gap, HST + 1); end
  endtask

  task automatic test_short_line();
    int d0, e0;
    d0 = de_cnt; e0 = err_pulses;
    g_short = 7;
    send_frame();
    g_short = -1;
    n_cmp++; if (err_pulses - e0 !== 1) begin n_bad++; $display("FAIL short_err_pulses: got %0d want 1", err_pulses - e0); end
    n_cmp++; if (err_cnt !== 8'd1) begin n_bad++; $display("FAIL short_err_cnt: got %0d want 1", err_cnt); end
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL short_locked: got %0d want 0", locked); end
    n_cmp++; if (unlock_cyc !== err_cyc) begin n_bad++; $display("FAIL short_unlock_time: got %0d want %0d", unlock_cyc, err_cyc); end
    n_cmp++; if (err_gap !== 1) begin n_bad++; $display("FAIL short_err_time: got %0d want 1", err_gap); end
    n_cmp++; if (de_cnt - d0 !== 3 * HAP) begin n_bad++; $display("FAIL short_de_cnt: got %0d want %0d", de_cnt - d0, 3 * HAP); end
    d0 = de_cnt;
    send_frame();
    n_cmp++; if (de_cnt - d0 !== 0) begin n_bad++; $display("FAIL short_de_measure: got %0d want 0", de_cnt - d0); end
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL short_locked_measure: got %0d want 0", locked); end
    d0 = de_cnt;
    send_frame();
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL short_relock: got %0d want 1", locked); end
    n_cmp++; if (de_cnt - d0 !== HAP * VAP) begin n_bad++; $display("FAIL short_de_relock: got %0d want %0d", de_cnt - d0, HAP * VAP); end
  endtask

  task automatic test_hs_width();
    int e0, l0;
    e0 = err_pulses; l0 = lock_rises;
    g_hs_w = HSW - 1;
    send_frame();
    send_frame();
    g_hs_w = HSW;
    n_cmp++; if (err_cnt !== 8'd3) begin n_bad++; $display("FAIL hsw_err_cnt: got %0d want 3", err_cnt); end
    n_cmp++; if (err_pulses - e0 !== 2) begin n_bad++; $display("FAIL hsw_err_pulses: got %0d want 2", err_pulses - e0); end
    n_cmp++; if (lock_rises - l0 !== 0) begin n_bad++; $display("FAIL hsw_lock_rises: got %0d want 0", lock_rises - l0); end
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL hsw_locked: got %0d want 0", locked); end
    n_cmp++; if (err_gap !== HSW) begin n_bad++; $display("FAIL hsw_err_time: got %0d want %0d", err_gap, HSW); end
  endtask

  // short pseudo-frames: each enters MEASURE and fails the hs width check
  task automatic test_saturation();
    int e0;
    e0 = err_pulses;
    repeat (252) begin
      drive_raw(1'b0, 1'b1, 24'h0);
      drive_raw(1'b1, 1'b1, 24'h0);
      drive_raw(1'b0, 1'b0, 24'h0);
      drive_raw(1'b1, 1'b0, 24'h0);
    end
    repeat (2) drive_raw(1'b1, 1'b1, 24'h0);
    n_cmp++; if (err_cnt !== 8'd255) begin n_bad++; $display("FAIL sat_reach: got %0d want 255", err_cnt); end
    n_cmp++; if (err_pulses - e0 !== 252) begin n_bad++; $display("FAIL sat_pulses_a: got %0d want 252", err_pulses - e0); end
    repeat (10) begin
      drive_raw(1'b0, 1'b1, 24'h0);
      drive_raw(1'b1, 1'b1, 24'h0);
      drive_raw(1'b0, 1'b0, 24'h0);
      drive_raw(1'b1, 1'b0, 24'h0);
    end
    repeat (2) drive_raw(1'b1, 1'b1, 24'h0);
    n_cmp++; if (err_cnt !== 8'd255) begin n_bad++; $display("FAIL sat_hold: got %0d want 255", err_cnt); end
    n_cmp++; if (err_pulses - e0 !== 262) begin n_bad++; $display("FAIL sat_pulses_b: got %0d want 262", err_pulses - e0); end
  endtask

  task automatic test_reset_mid();
    int d0;
    send_frame();
    send_frame();
    for (int l = 0; l < 6; l++)
      for (int c = 0; c < LP; c++) drive_px(l, c);
    for (int c = 0; c < 20; c++) drive_px(6, c);
    n_cmp++; if (de !== 1'b1) begin n_bad++; $display("FAIL mid_pre_de: got %0d want 1", de); end
    n_cmp++; if (px_x !== 10'd8 || px_y !== 10'd1) begin n_bad++; $display("FAIL mid_pre_xy: got %0d,%0d want 8,1", px_x, px_y); end
    rst = 1'b1;
    drive_px(6, 20);
    @(negedge clk);
    n_cmp++; if (de !== 1'b0) begin n_bad++; $display("FAIL mid_de: got %0d want 0", de); end
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL mid_locked: got %0d want 0", locked); end
    n_cmp++; if (err_cnt !== 8'd0) begin n_bad++; $display("FAIL mid_err_cnt: got %0d want 0", err_cnt); end
    n_cmp++; if ({px_x, px_y} !== 20'd0) begin n_bad++; $display("FAIL mid_xy: got %0d,%0d want 0,0", px_x, px_y); end
    n_cmp++; if (meas_line_len !== 11'd0 || meas_frame_lines !== 10'd0) begin n_bad++; $display("FAIL mid_meas: got %0d,%0d want 0,0", meas_line_len, meas_frame_lines); end
    rst = 1'b0;
    for (int c = 21; c < LP; c++) drive_px(6, c);
    for (int l = 7; l < FP; l++)
      for (int c = 0; c < LP; c++) drive_px(l, c);
    d0 = de_cnt;
    send_frame();
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL mid_locked_measure: got %0d want 0", locked); end
    n_cmp++; if (de_cnt - d0 !== 0) begin n_bad++; $display("FAIL mid_de_measure: got %0d want 0", de_cnt - d0); end
    d0 = de_cnt;
    send_frame();
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL mid_relock: got %0d want 1", locked); end
    n_cmp++; if (de_cnt - d0 !== HAP * VAP) begin n_bad++; $display("FAIL mid_de_relock: got %0d want %0d", de_cnt - d0, HAP * VAP); end
    n_cmp++; if (meas_frame_lines !== 10'(FP)) begin n_bad++; $display("FAIL mid_frame_lines: got %0d want %0d", meas_frame_lines, FP); end
    n_cmp++; if (err_cnt !== 8'd0) begin n_bad++; $display("FAIL mid_err_after: got %0d want 0", err_cnt); end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_pattern();
    test_short_line();
    test_hs_width();
    test_saturation();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
